// File: rtl/simd_mult_pkg.sv
// Shared definitions for the SIMD multiplier pipeline: mode encodings and
// the helpers that derive lane operand widths from the full operand widths.
package simd_mult_pkg;

  localparam logic [1:0] MODE_FULL  = 2'b00;  // one A_W x B_W product
  localparam logic [1:0] MODE_2LANE = 2'b01;  // two independent half-width lanes
  localparam logic [1:0] MODE_4LANE = 2'b10;  // four independent quarter-width lanes
  localparam logic [1:0] MODE_SUM2  = 2'b11;  // sum of the two half-width lane products

  // Operand slice width of one lane in two-lane mode.
  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Operand slice width of one lane in four-lane mode.
  function automatic int quarter_w(input int w);
    return w / 4;
  endfunction

endpackage

// File: rtl/simd_multiplier_pipe_if.sv
// Operand/result bus of simd_multiplier_pipe: a valid/ready operand channel
// and a valid/ready result channel. master drives operands, slave is the DUT.
interface simd_multiplier_pipe_if #(
  parameter int A_W = 32,
  parameter int B_W = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic               a_sign;
  logic               b_sign;
  logic [1:0]         mode;
  logic               acc_clear;
  logic               out_valid;
  logic               out_ready;
  logic [A_W+B_W-1:0] result;

  modport master (
    output in_valid, a, b, a_sign, b_sign, mode, acc_clear, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, a_sign, b_sign, mode, acc_clear, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/simd_mult_lane.sv
// One lane multiplier. Each operand carries its own signedness flag so the
// same lane can form either a true signed product or one partial product of
// a wider multiplication (where only the top slice is signed). The output is
// one bit wider than AW+BW so an unsigned x unsigned product is still a
// correct two's-complement value when the caller sign-extends it.
module simd_mult_lane #(
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic [AW-1:0]   a,
  input  logic [BW-1:0]   b,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic [AW+BW:0]  p
);

  logic signed [AW+BW:0] a_w;
  logic signed [AW+BW:0] b_w;

  // Extend each operand to the product width, honouring its signedness.
  assign a_w = {{(BW+1){a_signed & a[AW-1]}}, a};
  assign b_w = {{(AW+1){b_signed & b[BW-1]}}, b};

  // The true product always fits in AW+BW+1 signed bits, so truncation is exact.
  assign p = a_w * b_w;

endmodule

// File: rtl/simd_multiplier_pipe.sv
// SIMD multiplier with a two-stage valid/ready pipeline.
//   stage 1: captured operands, signs, mode (and clear flag)
//   stage 2: composed product (or accumulator value)
// Four half-width lane multipliers are shared by all modes: in full mode they
// form the four cross partial products, in two-lane/sum modes lanes 0 and 3
// do the work, and in four-lane mode each takes one quarter slice.
// Optional feature macro: SIMD_MULT_ACC_EN adds an ACC_W accumulator that
// absorbs every product as it enters stage 2 (ACC_W must exceed A_W+B_W).
module simd_multiplier_pipe
  import simd_mult_pkg::*;
#(
  parameter int A_W   = 32,
  parameter int B_W   = 16,
  parameter int ACC_W = A_W + B_W + 8
) (
  input logic                   clk,
  input logic                   rst_n,
  simd_multiplier_pipe_if.slave bus
);

  localparam int W  = A_W + B_W;
  localparam int HA = half_w(A_W);
  localparam int HB = half_w(B_W);
  localparam int QA = quarter_w(A_W);
  localparam int QB = quarter_w(B_W);
  localparam int P2 = HA + HB;      // result field per lane, two-lane mode
  localparam int P4 = QA + QB;      // result field per lane, four-lane mode
  localparam int LW = P2 + 1;       // lane multiplier output width

  logic           advance;
  logic           s1_valid;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic           s1_a_sign;
  logic           s1_b_sign;
  logic [1:0]     s1_mode;
  logic           s2_valid;

  logic [HA-1:0]  lane_a [4];
  logic [HB-1:0]  lane_b [4];
  logic [3:0]     lane_as;
  logic [3:0]     lane_bs;
  logic [LW-1:0]  lane_p [4];
  logic [W-1:0]   lane_x [4];
  logic [W-1:0]   prod;

  // Whole pipe moves together; it stalls only when a result is waiting.
  assign advance       = !s2_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = s2_valid;

  // Stage 1: capture operands and their mode together on every transfer.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: data registers are reset too, so result reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
      s1_mode   <= MODE_FULL;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a      <= bus.a;
        s1_b      <= bus.b;
        s1_a_sign <= bus.a_sign;
        s1_b_sign <= bus.b_sign;
        s1_mode   <= bus.mode;
      end
    end
  end

  // Steer operand slices and per-slice signedness onto the four lanes.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_a[k] = '0;
      lane_b[k] = '0;
    end
    lane_as = '0;
    lane_bs = '0;
    case (s1_mode)
      MODE_FULL: begin
        // Cross products; only the upper slice of each operand is signed.
        lane_a[0] = s1_a[HA-1:0];   lane_b[0] = s1_b[HB-1:0];
        lane_a[1] = s1_a[A_W-1:HA]; lane_b[1] = s1_b[HB-1:0];
        lane_a[2] = s1_a[HA-1:0];   lane_b[2] = s1_b[B_W-1:HB];
        lane_a[3] = s1_a[A_W-1:HA]; lane_b[3] = s1_b[B_W-1:HB];
        lane_as   = {s1_a_sign, 1'b0, s1_a_sign, 1'b0};
        lane_bs   = {s1_b_sign, s1_b_sign, 1'b0, 1'b0};
      end
      MODE_2LANE, MODE_SUM2: begin
        lane_a[0] = s1_a[HA-1:0];   lane_b[0] = s1_b[HB-1:0];
        lane_a[3] = s1_a[A_W-1:HA]; lane_b[3] = s1_b[B_W-1:HB];
        lane_as   = {s1_a_sign, 2'b00, s1_a_sign};
        lane_bs   = {s1_b_sign, 2'b00, s1_b_sign};
      end
      default: begin
        // Quarter slices extended to half width keep their value in the lane.
        for (int k = 0; k < 4; k++) begin
          lane_a[k] = {{QA{s1_a_sign & s1_a[k*QA+QA-1]}}, s1_a[k*QA +: QA]};
          lane_b[k] = {{QB{s1_b_sign & s1_b[k*QB+QB-1]}}, s1_b[k*QB +: QB]};
        end
        lane_as = {4{s1_a_sign}};
        lane_bs = {4{s1_b_sign}};
      end
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    simd_mult_lane #(
      .AW(HA),
      .BW(HB)
    ) u_lane (
      .a        (lane_a[k]),
      .b        (lane_b[k]),
      .a_signed (lane_as[k]),
      .b_signed (lane_bs[k]),
      .p        (lane_p[k])
    );
    assign lane_x[k] = {{(W-LW){lane_p[k][LW-1]}}, lane_p[k]};
  end

  // Compose the packed result; fields are cut from lane products so no
  // carry can cross a lane boundary.
  always_comb begin
    prod = '0;
    case (s1_mode)
      MODE_FULL:  prod = lane_x[0] + (lane_x[1] << HA) + (lane_x[2] << HB)
                         + (lane_x[3] << P2);
      MODE_2LANE: prod = {lane_p[3][P2-1:0], lane_p[0][P2-1:0]};
      MODE_4LANE: begin
        for (int k = 0; k < 4; k++) prod[k*P4 +: P4] = lane_p[k][P4-1:0];
      end
      default:    prod = lane_x[0] + lane_x[3];
    endcase
  end

  // Stage 2 valid: follows stage 1 whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_valid <= 1'b0;
    else if (advance) s2_valid <= s1_valid;
  end

`ifdef SIMD_MULT_ACC_EN
  logic             s1_clear;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;

  // Clear flag travels with its operands through stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_clear <= 1'b0;
    else if (advance && bus.in_valid) s1_clear <= bus.acc_clear;
  end

  // Next accumulator value: lane modes add field by field with wrap.
  always_comb begin
    acc_base = s1_clear ? '0 : acc;
    acc_next = acc_base;
    case (s1_mode)
      MODE_2LANE: begin
        for (int i = 0; i < 2; i++)
          acc_next[i*P2 +: P2] = acc_base[i*P2 +: P2] + prod[i*P2 +: P2];
      end
      MODE_4LANE: begin
        for (int i = 0; i < 4; i++)
          acc_next[i*P4 +: P4] = acc_base[i*P4 +: P4] + prod[i*P4 +: P4];
      end
      default: acc_next = acc_base
                          + {{(ACC_W-W){(s1_a_sign | s1_b_sign) & prod[W-1]}}, prod};
    endcase
  end

  // Accumulator absorbs each product as it enters stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (advance && s1_valid) acc <= acc_next;
  end

  assign bus.result = acc[W-1:0];
`else
  logic [W-1:0] s2_prod;
  logic         unused_acc_clear;

  // Stage 2 data: raw product, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_prod <= '0;
    else if (advance && s1_valid) s2_prod <= prod;
  end

  assign bus.result       = s2_prod;
  assign unused_acc_clear = bus.acc_clear;
`endif

endmodule

// File: doc/simd_multiplier_pipe.md
SIMD_MULTIPLIER_PIPE -- requirements
Module: simd_multiplier_pipe

Interface
REQ-001 Parameter A_W, default 32, multiplicand width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter B_W, default 16, multiplier width; SHALL be a multiple of 4 and at least 8.
REQ-003 Parameter ACC_W, default A_W+B_W+8, accumulator width; used only when SIMD_MULT_ACC_EN is defined.
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  operand transfer request.
REQ-007 in_ready  out  1  block can accept operands this cycle.
REQ-008 a  in  A_W  multiplicand, lane-packed (lane i at the lowest bits for lane 0).
REQ-009 b  in  B_W  multiplier, lane-packed.
REQ-010 a_sign, b_sign  in  1 each  operand is two's complement when 1.
REQ-011 mode  in  2  00 full, 01 two lanes, 10 four lanes, 11 sum of two lanes.
REQ-012 acc_clear  in  1  start a new accumulation with this transfer (accumulator builds only).
REQ-013 out_valid  out  1  result holds a valid product.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 result  out  A_W+B_W  packed product(s), or the accumulator value in accumulator builds.

Function
REQ-016 A transfer SHALL occur when in_valid and in_ready are both 1; a, b, a_sign, b_sign, mode and acc_clear SHALL be captured together.
REQ-017 The pipeline SHALL have two register stages: stage 1 holds the operands and stage 2 holds the products. out_valid SHALL rise exactly 2 cycles after the transfer when out_ready is held at 1.
REQ-018 advance = !out_valid | out_ready; in_ready SHALL equal advance. No transfer SHALL be lost, duplicated or reordered under any out_ready pattern.
REQ-019 Mode 00: result SHALL be the full A_W x B_W product, sign-extended when a_sign|b_sign.
REQ-020 Mode 01: lane i (i=0,1) SHALL multiply the A_W/2 slice i by the B_W/2 slice i. The product is placed at result bits [(i+1)*P2-1 : i*P2], where P2 = (A_W+B_W)/2.
REQ-021 Mode 10: four lanes, each A_W/4 x B_W/4, packed the same way with P4 = (A_W+B_W)/4.
REQ-022 Mode 11: result SHALL be the sum of the two mode-01 lane products, sign-extended to A_W+B_W bits when signed, truncated otherwise.
REQ-023 Lane signedness SHALL follow a_sign and b_sign for every lane; no carry SHALL cross lane boundaries.
REQ-024 Mode SHALL travel with its data, so back-to-back transfers in different modes each produce correct results.
REQ-025 While out_valid=1 and out_ready=0, result and out_valid SHALL hold stable.

Reset
REQ-026 With rst_n=0, both stage valid bits, out_valid and result SHALL be 0 immediately, and the accumulator SHALL be 0. in_ready SHALL be 1 from the first clock after rst_n is released.
REQ-027 Reset mid-operation SHALL discard in-flight transfers; no out_valid pulse SHALL follow the release of reset.

Configuration
REQ-028 Macro SIMD_MULT_ACC_EN: when defined, an ACC_W accumulator register SHALL be updated with each stage-2 product as the product enters stage 2.
- acc_clear=1: the accumulator loads that product.
- acc_clear=0: the product is added to the current value.
- result SHALL be the low A_W+B_W bits of the accumulator after the update.
- Lane modes 01 and 10 SHALL accumulate per lane, each lane wrapping within its own field.
REQ-029 When SIMD_MULT_ACC_EN is not defined, there SHALL be no accumulator, acc_clear SHALL be ignored, and result SHALL be the raw product.

Structure
REQ-030 A shared package simd_mult_pkg SHALL hold the mode encodings (MODE_FULL, MODE_2LANE, MODE_4LANE, MODE_SUM2) and the lane-width helper functions.
REQ-031 The lane multiplier SHALL be a sub-module simd_mult_lane (signed/unsigned, parametrised width). It is instantiated four times; the full and two-lane products are composed from shifted lane products.

Verification
REQ-032 Full mode (A_W=32, B_W=16): a=32'hFFFFFFFF, b=16'h0003, signs 1 -> result=48'hFFFFFFFFFFFD, 2 cycles after the transfer.
REQ-033 Two lanes, unsigned: a={16'd300,16'd5}, b={8'd2,8'd7} -> result[23:0]=35 and result[47:24]=600.
REQ-034 Four lanes, unsigned: a=32'h04030201, b=16'h4321 -> 12-bit fields 1, 4, 9, 16 (lowest field first).
REQ-035 Sum mode, signed: a={-16'd2,16'd3}, b={8'd4,-8'd5} -> result=48'hFFFFFFFFFFE9 (-23).
REQ-036 Backpressure: out_ready=0 for 5 cycles while 4 transfers are offered -> in_ready drops once both stages are full. After out_ready=1, all results appear in order with no loss.
REQ-037 Reset mid-pipe and accumulator:
- Assert rst_n=0 with 2 transfers in flight -> out_valid=0 after release.
- With SIMD_MULT_ACC_EN, mode 00: 3*4 with acc_clear=1, then 5*6 -> results 12, then 42.
